// File: rtl/tiny_dnn_pkg.sv
// Shared widths, output-position type and address helper for the tiny DNN
// output path.
package tiny_dnn_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;
    localparam int ADDR_W    = 12;

    typedef logic [ADDR_W-1:0] addr_t;

    // Output position counters: channel, row, column (ox innermost).
    typedef struct packed {
        logic [3:0] oc;
        logic [4:0] oy;
        logic [4:0] ox;
    } pos_t;

    // oc*os + oy*(ow+1) + ox, evaluated modulo 2**ADDR_W.
    function automatic addr_t calc_addr(pos_t p, logic [9:0] os, logic [4:0] ow);
        addr_t c, s, y, x, w;
        c = addr_t'(p.oc);
        s = addr_t'(os);
        y = addr_t'(p.oy);
        x = addr_t'(p.ox);
        w = addr_t'(ow) + addr_t'(1);
        return c * s + y * w + x;
    endfunction

endpackage

// File: rtl/tiny_dnn_out_ctl_if.sv
// Output-memory write port of the tiny DNN output controller.
interface tiny_dnn_out_ctl_if import tiny_dnn_pkg::*; #(
    parameter int OUT_W = OUT_W_DEF
);
    // A write transfers on every rising edge where o_we and o_ready are both
    // high; while o_we is high and o_ready low, o_addr/o_data hold unchanged.
    logic             o_we;
    addr_t            o_addr;
    logic [OUT_W-1:0] o_data;
    logic             o_ready;

    modport master (output o_we, output o_addr, output o_data, input o_ready);
    modport slave  (input o_we, input o_addr, input o_data, output o_ready);
endinterface

// File: rtl/tiny_dnn_out_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is taken only when
// a pop happens in the same cycle.
module tiny_dnn_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tiny_dnn_out_ctl.sv
// Output controller: converts finished kernel accumulators to output words,
// assigns each its output-memory address and queues it for writing.
module tiny_dnn_out_ctl import tiny_dnn_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_init,
    input  logic                    k_fin,
    input  logic signed [ACC_W-1:0] acc,
    input  logic                    relu,
    input  logic [3:0]              od,
    input  logic [4:0]              oh,
    input  logic [4:0]              ow,
    input  logic [9:0]              os,
    output logic                    out_busy,
    output logic                    outr,
    output logic                    err,
    tiny_dnn_out_ctl_if.master      wr
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_W + OUT_W;
    // Saturation limits assume ACC_W > OUT_W.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    pos_t                    pos, pos_nxt;
    logic                    done;
    logic                    last;
    logic signed [ACC_W-1:0] shifted;
    logic [OUT_W-1:0]        conv;
    logic [EW-1:0]           head;
    logic [CW-1:0]           count;
    logic                    fifo_full, fifo_empty;
    logic                    pop, push, drop, kfin_live, blocked;

    always_comb begin
        shifted = acc >>> SHIFT;
        conv    = shifted[OUT_W-1:0];
        if (relu && shifted[ACC_W-1]) conv = '0;
        else if (shifted > SAT_MAX)   conv = SAT_MAX[OUT_W-1:0];
        else if (shifted < SAT_MIN)   conv = SAT_MIN[OUT_W-1:0];
    end

    always_comb begin
        pos_nxt = pos;
        last    = (pos.ox == ow) && (pos.oy == oh) && (pos.oc == od);
        if (pos.ox != ow) begin
            pos_nxt.ox = pos.ox + 5'd1;
        end else begin
            pos_nxt.ox = '0;
            if (pos.oy != oh) begin
                pos_nxt.oy = pos.oy + 5'd1;
            end else begin
                pos_nxt.oy = '0;
                pos_nxt.oc = pos.oc + 4'd1;
            end
        end
    end

    // s_init swallows a coincident k_fin without flagging it.
    assign pop       = wr.o_we & wr.o_ready;
    assign kfin_live = k_fin & ~s_init;
    assign blocked   = done | (fifo_full & ~pop);
    assign push      = kfin_live & ~blocked;
    assign drop      = kfin_live & blocked;

    always_ff @(posedge clk) begin
        if (rst || s_init) begin
            pos  <= '0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (push) begin
                if (last) done <= 1'b1;
                else      pos  <= pos_nxt;
            end
            if (drop) err <= 1'b1;
        end
    end

    tiny_dnn_out_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({calc_addr(pos, os, ow), conv}),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wr.o_we   = ~fifo_empty & ~rst;
    assign wr.o_addr = wr.o_we ? head[EW-1:OUT_W] : '0;
    assign wr.o_data = wr.o_we ? head[OUT_W-1:0] : '0;
    assign out_busy  = (count >= CW'(DEPTH - 1));
    assign outr      = (count != '0);
endmodule

// File: doc/tiny_dnn_out_ctl.md
TINY_DNN_OUT_CTL -- requirements
Module: tiny_dnn_out_ctl

Interface
REQ-001 Parameters SHALL be: ACC_W, default 32, accumulator width; OUT_W, default 16, output word width; SHIFT, default 8, fixed-point right shift; DEPTH, default 4, result FIFO entries (power of 2, at least 2).
REQ-002 clk  in  1  the one clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 s_init  in  1  start-of-layer pulse; SHALL clear the address counters and err.
REQ-005 k_fin  in  1  kernel-finished pulse; acc is valid in the same cycle.
REQ-006 acc  in  ACC_W  signed accumulator result.
REQ-007 relu  in  1  when high, negative results SHALL become 0.
REQ-008 od  in  4, oh  in  5, ow  in  5  inclusive final values of the channel, row and column counters.
REQ-009 os  in  10  output channel stride, in words.
REQ-010 out_busy  out  1  asks the execute controller to hold the next kernel start.
REQ-011 outr  out  1  high while any captured result is not yet written to output memory.
REQ-012 o_we  out  1, o_addr  out  12, o_data  out  OUT_W  output-memory write request.
REQ-013 o_ready  in  1  output memory accepts the write in the cycle o_we and o_ready are both high.
REQ-014 err  out  1  sticky protocol-error flag.

Function
REQ-015 Address counters: oc 4 bits, oy 5 bits, ox 5 bits, nested with ox innermost.
- On an accepted k_fin, ox SHALL increment; it wraps to 0 after ow and carries to oy.
- oy SHALL wrap to 0 after oh and carry to oc.
- After (od,oh,ow), the counters SHALL hold and set the internal flag done.
REQ-016 Capture address SHALL be oc*os + oy*(ow+1) + ox, computed from the counter values before the increment, truncated to 12 bits.
REQ-017 Data conversion SHALL be: arithmetic shift acc right by SHIFT; apply relu; saturate to the signed OUT_W range.
REQ-018 An accepted k_fin SHALL push {address, converted data} into the FIFO in the same cycle; each entry keeps its own address.
REQ-019 Head-of-FIFO write port:
- o_we SHALL be high exactly when the FIFO is non-empty.
- o_addr and o_data SHALL show the head entry and SHALL stay stable while o_we is high and o_ready is low.
- o_we with o_ready SHALL pop the head entry.
REQ-020 Latency: with the FIFO empty, k_fin in cycle N SHALL give o_we=1 in cycle N+1 at the earliest.
REQ-021 out_busy SHALL be 1 when the FIFO count is at least DEPTH-1, driven from registered count only.
REQ-022 outr SHALL be 1 when the count is non-zero.
REQ-023 Full FIFO:
- k_fin with a pop in the same cycle SHALL be accepted, count unchanged.
- k_fin with no pop SHALL be dropped: no counter advance, err set.
REQ-024 k_fin while done is high SHALL be dropped and SHALL set err.
REQ-025 s_init during k_fin: s_init SHALL win, the k_fin SHALL be dropped, and err SHALL NOT be set.
REQ-026 s_init SHALL NOT flush FIFO entries already captured; they drain with their stored addresses.
REQ-027 Simultaneous push and pop with count 0 cannot occur, because o_we is low when the FIFO is empty.

Reset
REQ-028 rst SHALL clear oc, oy, ox, done, the FIFO pointers and count, and err, and SHALL drive o_we=0, out_busy=0, outr=0.
REQ-029 After reset, o_addr and o_data SHALL be 0.
REQ-030 rst mid-drain SHALL discard all pending entries, with no write in the reset cycle.
REQ-031 rst SHALL take priority over s_init and k_fin.

Structure
REQ-032 ACC_W and OUT_W defaults and the address width (12) SHALL live in the shared package tiny_dnn_pkg.
REQ-033 The FIFO SHALL be a separate sub-module, tiny_dnn_out_fifo: synchronous, parameterised width and depth, with push/pop/count/full/empty.

Verification
REQ-034 Setup: od=0, oh=1, ow=1, os=4, o_ready=1; four k_fin pulses with acc=0x100, 0x200, 0x300, 0x400 -> writes (addr 0, data 1), (addr 1, data 2), (addr 2, data 3), (addr 3, data 4); done set; outr falls one cycle after the last write.
REQ-035 relu=1, acc=-512 -> o_data=0; relu=0, acc=-512 -> o_data=0xFFFE; acc=0x7FFFFFFF -> o_data=0x7FFF (saturated).
REQ-036 o_ready=0; three k_fin -> out_busy=1 after the third push, o_addr/o_data stable; a fourth k_fin -> accepted, FIFO full; a fifth k_fin -> dropped, err=1; release o_ready -> four writes in order.
REQ-037 od=1, oh=0, ow=0, os=16 -> addresses 0 and 16; a third k_fin -> err=1 with no write.
REQ-038 rst asserted with 2 entries pending -> o_we=0 the next cycle, no further writes, outr=0, counters at 0.
REQ-039 s_init in the same cycle as k_fin, with 1 entry pending -> the pending entry still writes its original address, the new k_fin is not captured, err=0.
